keypad_digit_capture: RTL and testbench

KEYPAD_DIGIT_CAPTURE -- requirements
Module: keypad_digit_capture

---
 rtl/keypad_pkg.sv | 31 +++
 rtl/debounce_timer.sv | 25 ++
 rtl/keypad_digit_capture.sv | 156 +++++++++++++++
 tb/tb_keypad_digit_capture.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and key-code mapping for the keypad digit capture block.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      HELD,
      RELEASE
   } state_t;

   // Row-major legend of a standard 4x4 telephone-style keypad.
   localparam logic [3:0] KEY_MAP [16] = '{
      4'h1, 4'h2, 4'h3, 4'hA,
      4'h4, 4'h5, 4'h6, 4'hB,
      4'h7, 4'h8, 4'h9, 4'hC,
      4'hE, 4'h0, 4'hF, 4'hD
   };

   function automatic logic [3:0] key_lut(input int nrows, input int ncols,
                                          input int row, input int col);
      logic [3:0] idx;
      int         code;
      if (nrows == 4 && ncols == 4) begin
         idx = {row[1:0], col[1:0]};
         return KEY_MAP[idx];
      end
      code = row * ncols + col;
      return code[3:0];
   endfunction

endpackage

// File: rtl/debounce_timer.sv
// Saturating stable-level timer shared by press and release debouncing.
module debounce_timer #(
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic done
);

   localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

   logic [W-1:0] count;

   // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset)                count <= '0;
      else if (clear)            count <= '0;
      else if (enable && !done)  count <= count + W'(1);
   end

   assign done = (count == W'(LIMIT - 1));

endmodule

// File: rtl/keypad_digit_capture.sv
// Row-scanning keypad reader with debounce, single-shot key strobe and digit history.
module keypad_digit_capture #(
   parameter int NROWS      = 4,
   parameter int NCOLS      = 4,
   parameter int SCAN_DIV   = 4800,
   parameter int DEB_CYCLES = 960000,
   parameter int NDIGITS    = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NCOLS-1:0]       columns,
   output logic [NROWS-1:0]       rows,
   output logic [3:0]             key_code,
   output logic                   key_valid,
   output logic                   key_held,
   output logic [4*NDIGITS-1:0]   digits
);

   import keypad_pkg::*;

   localparam int RW = (NROWS > 1) ? $clog2(NROWS) : 1;
   localparam int CW = (NCOLS > 1) ? $clog2(NCOLS) : 1;
   localparam int SW = $clog2(SCAN_DIV);
   localparam int DW = 4 * NDIGITS;

   if (NROWS * NCOLS > 16) begin : g_geom_check
      $error("keypad_digit_capture: NROWS*NCOLS must not exceed 16");
   end
   if (SCAN_DIV < 3) begin : g_div_check
      $error("keypad_digit_capture: SCAN_DIV must be at least 3");
   end

   // Row must be driven this long before cols_s reflects it through the synchronizer.
   localparam logic [SW-1:0] SETTLE    = SW'(2);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

   state_t          state, next_state;
   logic [NCOLS-1:0] cols_m, cols_s;
   logic [RW-1:0]   row_idx, next_row;
   logic [CW-1:0]   col_idx, low_col;
   logic [SW-1:0]   scan_cnt;
   logic            key_seen, col_level;
   logic            capture, accept, row_step;
   logic            tmr_clear, tmr_en, tmr_done;
   logic [3:0]      new_code;

   debounce_timer #(.LIMIT(DEB_CYCLES)) u_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (tmr_clear),
      .enable (tmr_en),
      .done   (tmr_done)
   );

   always_comb begin
      key_seen = (cols_s != '1);
      low_col  = '0;
      for (int i = NCOLS - 1; i >= 0; i--) begin
         if (!cols_s[i]) low_col = CW'(i);
      end
   end

   assign col_level = cols_s[col_idx];
   assign next_row  = (row_idx == RW'(NROWS - 1)) ? '0 : row_idx + RW'(1);
   assign new_code  = key_lut(NROWS, NCOLS, int'(row_idx), int'(col_idx));

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      next_state = state;
      capture    = 1'b0;
      accept     = 1'b0;
      row_step   = 1'b0;
      tmr_clear  = 1'b0;
      tmr_en     = 1'b0;
      unique case (state)
         SCAN: begin
            tmr_clear = 1'b1;
            if (key_seen && scan_cnt >= SETTLE) begin
               next_state = DEBOUNCE;
               capture    = 1'b1;
            end else if (scan_cnt == SCAN_LAST) begin
               row_step = 1'b1;
            end
         end
         DEBOUNCE: begin
            if (col_level) begin
               next_state = SCAN;
               row_step   = 1'b1;
               tmr_clear  = 1'b1;
            end else if (tmr_done) begin
               next_state = HELD;
               accept     = 1'b1;
               tmr_clear  = 1'b1;
            end else begin
               tmr_en = 1'b1;
            end
         end
         HELD: begin
            if (col_level) begin
               next_state = RELEASE;
               tmr_clear  = 1'b1;
            end
         end
         RELEASE: begin
            if (!col_level) begin
               next_state = HELD;
               tmr_clear  = 1'b1;
            end else if (tmr_done) begin
               next_state = SCAN;
               row_step   = 1'b1;
               tmr_clear  = 1'b1;
            end else begin
               tmr_en = 1'b1;
            end
         end
         default: next_state = SCAN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= SCAN;
         cols_m    <= '1;
         cols_s    <= '1;
         row_idx   <= '0;
         col_idx   <= '0;
         scan_cnt  <= '0;
         key_code  <= '0;
         key_valid <= 1'b0;
         digits    <= '0;
      end else begin
         cols_m    <= columns;
         cols_s    <= cols_m;
         state     <= next_state;
         key_valid <= accept;
         if (capture) col_idx <= low_col;
         if (accept) begin
            key_code <= new_code;
            digits   <= (digits << 4) | DW'(new_code);
         end
         if (row_step) begin
            row_idx  <= next_row;
            scan_cnt <= '0;
         end else if (state == SCAN && next_state == SCAN) begin
            scan_cnt <= scan_cnt + SW'(1);
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NROWS; i++) rows[i] = (row_idx != RW'(i));
   end

   assign key_held = (state == HELD) || (state == RELEASE);

endmodule

// File: tb/tb_keypad_digit_capture.sv
// Directed bench: keypad switch model, scoreboard of expected key strobes, immediate assertions.
module tb_keypad_digit_capture;

   localparam int NROWS = 4;
   localparam int NCOLS = 4;

   typedef struct packed {
      logic [3:0] code;
      logic [7:0] digits;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic [NCOLS-1:0] columns;
   logic [NROWS-1:0] rows;
   logic [3:0]       key_code;
   logic             key_valid;
   logic             key_held;
   logic [7:0]       digits;

   // Independent legend of the 4x4 keypad, row-major.
   logic [3:0] legend [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

   int   n_checks = 0;
   int   n_fail = 0;
   int   valid_count = 0;
   exp_t sb[$];
   logic [7:0] exp_digits = 8'h00;

   logic pressed = 1'b0;
   int   prow = 0;
   int   pcol = 0;

   always #5 clk = ~clk;

   // Switch model: the pressed key shorts its column low only while its row is driven.
   assign columns = (pressed && rows[prow] == 1'b0) ? ~(4'b0001 << pcol) : 4'hF;

   keypad_digit_capture #(
      .NROWS(NROWS), .NCOLS(NCOLS), .SCAN_DIV(8), .DEB_CYCLES(16), .NDIGITS(2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .columns   (columns),
      .rows      (rows),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held),
      .digits    (digits)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (key_valid === 1'b1) begin
         exp_t e;
         valid_count++;
         if (sb.size() == 0) begin
            check("valid_expected", 32'(sb.size()), 32'd1);
         end else begin
            e = sb.pop_front();
            check("strobe_code", 32'(key_code), 32'(e.code));
            check("strobe_digits", 32'(digits), 32'(e.digits));
         end
      end
   end

   task automatic wait_rows(input int row, input string tag);
      logic [3:0] want;
      want = ~(4'b0001 << row);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (rows == want) break;
      end
      check(tag, 32'(rows), 32'(want));
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (key_held == 1'b0) break;
      end
      check(tag, 32'(key_held), 32'd0);
      repeat (4) @(negedge clk);
   endtask

   task automatic expect_key(input int row, input int col);
      exp_t e;
      e.code     = legend[row * 4 + col];
      exp_digits = {exp_digits[3:0], e.code};
      e.digits   = exp_digits;
      sb.push_back(e);
   endtask

   task automatic press_key(input int row, input int col, input int hold);
      wait_rows(row, "reach_row");
      prow = row;
      pcol = col;
      pressed = 1'b1;
      expect_key(row, col);
      repeat (hold) @(posedge clk);
      #1 pressed = 1'b0;
      wait_idle("released");
   endtask

   initial begin
      // Reset held for three edges.
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_rows", 32'(rows), 32'h0000_000E);
      check("rst_digits", 32'(digits), 32'h0);
      check("rst_valid", 32'(key_valid), 32'h0);
      check("rst_held", 32'(key_held), 32'h0);
      check("rst_code", 32'(key_code), 32'h0);
      reset = 1'b1;

      // Clean press of row 2 / column 1 held for 40 cycles.
      wait_rows(2, "clean_row2");
      prow = 2;
      pcol = 1;
      pressed = 1'b1;
      expect_key(2, 1);
      repeat (40) @(posedge clk);
      @(negedge clk);
      check("clean_held", 32'(key_held), 32'h1);
      check("clean_code", 32'(key_code), 32'h8);
      check("clean_digits", 32'(digits), 32'h08);
      check("clean_one_valid", 32'(valid_count), 32'd1);
      pressed = 1'b0;
      wait_idle("clean_release");

      // Bounce: 5 low cycles on row 2 must freeze the row, then resume at row 3.
      wait_rows(2, "bounce_row2");
      repeat (3) @(posedge clk);
      #1;
      prow = 2;
      pcol = 1;
      pressed = 1'b1;
      repeat (5) @(posedge clk);
      #1 pressed = 1'b0;
      @(negedge clk);
      check("bounce_frozen", 32'(rows), 32'h0000_000B);
      check("bounce_not_held", 32'(key_held), 32'h0);
      wait_rows(3, "bounce_resume_row3");
      check("bounce_no_valid", 32'(valid_count), 32'd1);

      // Two presses: 5 then C.
      press_key(1, 1, 30);
      press_key(2, 3, 30);
      check("two_digits", 32'(digits), 32'h5C);
      check("two_valids", 32'(valid_count), 32'd3);

      // Release glitch: column returns low for 3 cycles during release debounce.
      wait_rows(0, "glitch_row0");
      prow = 0;
      pcol = 0;
      pressed = 1'b1;
      expect_key(0, 0);
      repeat (30) @(posedge clk);
      #1 pressed = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("glitch_in_release", 32'(key_held), 32'h1);
      pressed = 1'b1;
      repeat (3) @(posedge clk);
      #1 pressed = 1'b0;
      repeat (12) @(posedge clk);
      @(negedge clk);
      check("glitch_restart", 32'(key_held), 32'h1);
      wait_idle("glitch_release");
      check("glitch_one_valid", 32'(valid_count), 32'd4);
      check("glitch_digits", 32'(digits), 32'hC1);

      // Reset asserted at debounce count 10.
      wait_rows(3, "rstdeb_row3");
      prow = 3;
      pcol = 1;
      pressed = 1'b1;
      repeat (13) @(posedge clk);
      #1 reset = 1'b0;
      pressed = 1'b0;
      exp_digits = 8'h00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rstdeb_rows", 32'(rows), 32'h0000_000E);
      check("rstdeb_held", 32'(key_held), 32'h0);
      check("rstdeb_valid", 32'(key_valid), 32'h0);
      check("rstdeb_digits", 32'(digits), 32'h0);
      reset = 1'b1;
      repeat (30) @(negedge clk);
      check("rstdeb_no_valid", 32'(valid_count), 32'd4);
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
